pc_sequencer: RTL and testbench

Fetch/sequencing controller for the single-issue RISC-V core. It owns the program counter and the fetch→execute instruction register, and redirects fetch on taken branches/jumps by squashing the wrong-path instruction. It holds the front end while a multi-cycle execute operation is busy, stops the core on a halt, and counts retired instructions. It sits between instruction memory and the decoder, replacing the free-running `pc_F + 4` register pair.

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and the fetch->execute instruction
// register. Redirects fetch on taken branches (squashing the wrong-path
// fetch), holds the front end while EX is busy, stops on halt, and counts
// retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               res,
    input  logic [31:0]        imem_rdata,
    input  logic               br_take_EX,
    input  logic [31:0]        br_target_EX,
    input  logic               stall_req,
    input  logic               halt_req,
    output logic [31:0]        pc_F,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        instruction_EX,
    output logic [31:0]        pc_EX,
    output logic               valid_EX,
    output logic               halted,
    output logic [31:0]        retired
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_pc_F;
    logic [31:0] r_instr_EX;
    logic [31:0] r_pc_EX;
    logic        r_valid_EX;
    logic        r_halted;
    logic [31:0] r_retired;

    // Requests only count when the EX slot holds a real instruction.
    logic        w_halt;
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_halt     = r_valid_EX & halt_req;
    assign w_stall    = r_valid_EX & stall_req;
    assign w_redirect = r_valid_EX & br_take_EX;
    // Low two target bits are dropped so fetch stays word aligned.
    assign w_target   = br_target_EX & ~32'h0000_0003;
    assign w_pc_inc   = r_pc_F + 32'd4;

    // Sequencer FSM: halt > stall > redirect > normal fetch while running.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= S_RUN;
            r_pc_F     <= RESET_PC;
            r_instr_EX <= NOP;
            r_pc_EX    <= 32'd0;
            r_valid_EX <= 1'b0;
            r_halted   <= 1'b0;
            r_retired  <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_halt) begin
                        // The halt instruction itself retires; fetch freezes.
                        r_state    <= S_HALT;
                        r_halted   <= 1'b1;
                        r_retired  <= r_retired + 32'd1;
                        r_valid_EX <= 1'b0;
                        r_instr_EX <= NOP;
                    end else if (w_stall) begin
                        // Hold everything; a branch in EX is re-evaluated on release.
                    end else if (w_redirect) begin
                        // Branch retires; the fetch already in flight is squashed.
                        r_pc_F     <= w_target;
                        r_instr_EX <= NOP;
                        r_valid_EX <= 1'b0;
                        r_retired  <= r_retired + 32'd1;
                    end else begin
                        r_instr_EX <= imem_rdata;
                        r_pc_EX    <= r_pc_F;
                        r_valid_EX <= 1'b1;
                        r_pc_F     <= w_pc_inc;
                        r_retired  <= r_retired + {31'd0, r_valid_EX};
                    end
                end
                S_HALT: begin
                    // Only reset leaves HALT.
                    r_valid_EX <= 1'b0;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign pc_F           = r_pc_F;
    assign imem_addr      = r_pc_F[IMEM_AW+1:2];
    assign instruction_EX = r_instr_EX;
    assign pc_EX          = r_pc_EX;
    assign valid_EX       = r_valid_EX;
    assign halted         = r_halted;
    assign retired        = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner
// sequences, then randomized requests checked against a behavioural model.
module tb_pc_sequencer;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic [31:0]   imem_rdata;
    logic          br_take_EX = 1'b0;
    logic [31:0]   br_target_EX = 32'd0;
    logic          stall_req = 1'b0;
    logic          halt_req = 1'b0;
    logic [31:0]   pc_F;
    logic [AW-1:0] imem_addr;
    logic [31:0]   instruction_EX;
    logic [31:0]   pc_EX;
    logic          valid_EX;
    logic          halted;
    logic [31:0]   retired;

    logic [31:0] mem [0:DEPTH-1];

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
        .clk(clk), .res(res), .imem_rdata(imem_rdata),
        .br_take_EX(br_take_EX), .br_target_EX(br_target_EX),
        .stall_req(stall_req), .halt_req(halt_req),
        .pc_F(pc_F), .imem_addr(imem_addr), .instruction_EX(instruction_EX),
        .pc_EX(pc_EX), .valid_EX(valid_EX), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    typedef struct {
        bit          rst;
        bit          br;
        logic [31:0] tgt;
        bit          st;
        bit          hl;
        logic [31:0] pf;
        logic [31:0] pe;
        logic [31:0] ins;
        bit          v;
        bit          h;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[$];

    // Directed-phase memory pattern: word at byte address a.
    function automatic logic [31:0] W(logic [31:0] a);
        return 32'hA500_0000 + {22'd0, a[11:2]};
    endfunction

    function automatic void add(bit rst, bit br, logic [31:0] tgt, bit st, bit hl,
                                logic [31:0] pf, logic [31:0] pe, logic [31:0] ins,
                                bit v, bit h, logic [31:0] r);
        vec_t e;
        e = '{rst, br, tgt, st, hl, pf, pe, ins, v, h, r};
        tbl.push_back(e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, logic [31:0] pf, logic [31:0] pe,
                             logic [31:0] ins, bit v, bit h, logic [31:0] r);
        logic [31:0] ea;
        ea = (pf >> 2) & (DEPTH - 1);
        chk({tag, ".pc_F"}, pc_F, pf);
        chk({tag, ".imem_addr"}, {22'd0, imem_addr}, ea);
        chk({tag, ".pc_EX"}, pc_EX, pe);
        chk({tag, ".instr_EX"}, instruction_EX, ins);
        chk({tag, ".valid_EX"}, {31'd0, valid_EX}, {31'd0, v});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
        chk({tag, ".retired"}, retired, r);
    endtask

    // Called at a negedge; pulses reset well clear of the rising edge.
    task automatic do_reset();
        res = 1'b1;
        #2;
        res = 1'b0;
    endtask

    // Drive inputs, take one rising edge, return at the following negedge.
    task automatic step(bit br, logic [31:0] tgt, bit st, bit hl);
        br_take_EX   = br;
        br_target_EX = tgt;
        stall_req    = st;
        halt_req     = hl;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural reference for the random phase.
    logic [31:0] m_pc, m_epc, m_ins, m_ret;
    bit          m_v, m_h;

    task automatic model_reset();
        m_pc = 32'd0; m_epc = 32'd0; m_ins = NOP; m_ret = 32'd0; m_v = 0; m_h = 0;
    endtask

    task automatic model_edge(bit br, logic [31:0] tgt, bit st, bit hl);
        if (m_h) return;
        if (m_v && hl) begin
            m_h = 1; m_v = 0; m_ins = NOP; m_ret = m_ret + 1;
        end else if (m_v && st) begin
            // frozen
        end else if (m_v && br) begin
            m_pc = {tgt[31:2], 2'b00}; m_ins = NOP; m_v = 0; m_ret = m_ret + 1;
        end else begin
            m_ret = m_ret + (m_v ? 32'd1 : 32'd0);
            m_ins = mem[(m_pc / 4) % DEPTH];
            m_epc = m_pc;
            m_v   = 1;
            m_pc  = m_pc + 32'd4;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 + i;

        // Sequential run
        add(1, 0, 0, 0, 0, 32'h00, 32'h00, NOP,       0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h04, 32'h00, W(32'h00), 1, 0, 0);
        add(0, 0, 0, 0, 0, 32'h08, 32'h04, W(32'h04), 1, 0, 1);
        add(0, 0, 0, 0, 0, 32'h0C, 32'h08, W(32'h08), 1, 0, 2);
        add(0, 0, 0, 0, 0, 32'h10, 32'h0C, W(32'h0C), 1, 0, 3);
        // Taken branch, bubble-ignored branch, misaligned target
        add(1, 0, 0, 0, 0, 32'h00, 32'h00, NOP,       0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h04, 32'h00, W(32'h00), 1, 0, 0);
        add(0, 0, 0, 0, 0, 32'h08, 32'h04, W(32'h04), 1, 0, 1);
        add(0, 0, 0, 0, 0, 32'h0C, 32'h08, W(32'h08), 1, 0, 2);
        add(0, 1, 32'h40, 0, 0, 32'h40, 32'h08, NOP,  0, 0, 3);
        add(0, 1, 32'h80, 0, 0, 32'h44, 32'h40, W(32'h40), 1, 0, 3);
        add(0, 1, 32'h43, 0, 0, 32'h40, 32'h40, NOP,  0, 0, 4);
        add(0, 0, 0, 0, 0, 32'h44, 32'h40, W(32'h40), 1, 0, 4);
        add(0, 0, 0, 0, 0, 32'h48, 32'h44, W(32'h44), 1, 0, 5);
        // Stall with branch asserted, then halt
        add(1, 0, 0, 0, 0, 32'h00, 32'h00, NOP,       0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h04, 32'h00, W(32'h00), 1, 0, 0);
        add(0, 0, 0, 0, 0, 32'h08, 32'h04, W(32'h04), 1, 0, 1);
        for (int k = 0; k < 3; k++)
            add(0, 1, 32'h100, 1, 0, 32'h08, 32'h04, W(32'h04), 1, 0, 1);
        add(0, 0, 0, 0, 0, 32'h0C, 32'h08, W(32'h08), 1, 0, 2);
        add(0, 0, 0, 0, 0, 32'h10, 32'h0C, W(32'h0C), 1, 0, 3);
        add(0, 0, 0, 0, 1, 32'h10, 32'h0C, NOP,       0, 1, 4);

        @(negedge clk);
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            else step(tbl[i].br, tbl[i].tgt, tbl[i].st, tbl[i].hl);
            check_all($sformatf("vec%0d", i), tbl[i].pf, tbl[i].pe, tbl[i].ins,
                      tbl[i].v, tbl[i].h, tbl[i].r);
        end

        // HALT ignores every request for 10 cycles
        for (int k = 0; k < 10; k++) begin
            step(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            check_all("halt_hold", 32'h10, 32'h0C, NOP, 0, 1, 4);
        end

        // Async reset in the middle of a stall with retired = 5
        do_reset();
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
        check_all("pre_stall", 32'h18, 32'h14, W(32'h14), 1, 0, 5);
        step(0, 0, 1, 0);
        check_all("stalled", 32'h18, 32'h14, W(32'h14), 1, 0, 5);
        #2 res = 1'b1;
        #1 check_all("async_rst", 32'h00, 32'h14 & 32'h0, NOP, 0, 0, 0);
        res = 1'b0;
        step(0, 0, 1, 0);
        check_all("resume", 32'h04, 32'h00, W(32'h00), 1, 0, 0);

        // Randomized phase against the behavioural model
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        do_reset();
        model_reset();
        begin
            int halt_cnt = 0;
            for (int n = 0; n < 3000; n++) begin
                bit          br, st, hl;
                logic [31:0] tgt;
                br  = ($urandom_range(0, 99) < 25);
                st  = ($urandom_range(0, 99) < 20);
                hl  = ($urandom_range(0, 199) == 0);
                tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : $urandom;
                if ($urandom_range(0, 99) == 0 || halt_cnt > 8) begin
                    res = 1'b1;
                    #1;
                    res = 1'b0;
                    #1;
                    model_reset();
                    halt_cnt = 0;
                    check_all("rnd_rst", m_pc, m_epc, m_ins, m_v, m_h, m_ret);
                end else begin
                    model_edge(br, tgt, st, hl);
                    step(br, tgt, st, hl);
                    if (m_h) halt_cnt++;
                    check_all("rnd", m_pc, m_epc, m_ins, m_v, m_h, m_ret);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
